// File: rtl/cla_addsub_pipe_pkg.sv
// Shared constants and helpers for the pipelined
// carry-lookahead adder/subtractor.
package cla_addsub_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int ngroups(input int w, input int g);
    return (w + g - 1) / g;
  endfunction

  function automatic int padw(input int w, input int g);
    return ngroups(w, g) * g;
  endfunction

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } ref_t;

  // Arithmetic model of one beat, widths up to 64 bits.
  function automatic ref_t ref_calc(
    input int          w,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        sub
  );
    ref_t        r;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic [64:0] full;
    logic        cm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + 65'(sub);
    cm   = full[w-1] ^ am[w-1] ^ bm[w-1];
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = full[w] ^ cm;
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

endpackage

// File: rtl/cla_group_gen.sv
// One lookahead group: flattened sum-of-products
// carries plus group propagate/generate.
module cla_group_gen #(
  parameter int GROUP = 3
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic [GROUP:1]   c,
  output logic             gp,
  output logic             gg
);

  function automatic logic la(
    input logic [GROUP-1:0] pv,
    input logic [GROUP-1:0] gv,
    input logic             ci,
    input int               n
  );
    logic r;
    logic t;
    r = ci;
    for (int j = 0; j < GROUP; j++)
      if (j < n) r = r & pv[j];
    for (int j = 0; j < GROUP; j++) begin
      if (j < n) begin
        t = gv[j];
        for (int k = 0; k < GROUP; k++)
          if (k > j && k < n) t = t & pv[k];
        r = r | t;
      end
    end
    return r;
  endfunction

  // Each carry is an independent product sum, no ripple.
  always_comb begin
    c = '0;
    for (int i = 1; i <= GROUP; i++)
      c[i] = la(p, g, cin, i);
  end

  assign gp = &p;
  assign gg = la(p, g, 1'b0, GROUP);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead add/sub
// with status flags and valid/ready handshake.
module cla_addsub_pipe
  import cla_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int GROUP = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG = ngroups(WIDTH, GROUP);
  localparam int PW = padw(WIDTH, GROUP);

  logic [WIDTH-1:0] bx;
  logic [PW-1:0]    ap;
  logic [PW-1:0]    bp;
  logic [PW-1:0]    p_in;
  logic [PW-1:0]    g_in;
  logic [NG-1:0]    gp_in;
  logic [NG-1:0]    gg_in;
  logic [PW-1:0]    s1_c_unused;

  logic             s1_valid;
  logic [PW-1:0]    s1_p;
  logic [PW-1:0]    s1_g;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;
  logic             s1_cin;

  logic             s2_valid;
  logic             s2_load;
  logic             s1_load;
  logic [NG-1:0]    gc;
  logic [PW:0]      cv;
  logic [NG-1:0]    s2_gp_unused;
  logic [NG-1:0]    s2_gg_unused;
  logic [WIDTH-1:0] sum_nxt;
  logic             t;
  logic             acc;

  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Pad bits stay zero so they never propagate.
  assign bx   = in_b ^ {WIDTH{in_sub == MODE_SUB}};
  assign ap   = PW'(in_a);
  assign bp   = PW'(bx);
  assign p_in = ap ^ bp;
  assign g_in = ap & bp;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla_group_gen #(.GROUP(GROUP)) u_grp (
      .p   (p_in[k*GROUP +: GROUP]),
      .g   (g_in[k*GROUP +: GROUP]),
      .cin (1'b0),
      .c   (s1_c_unused[k*GROUP +: GROUP]),
      .gp  (gp_in[k]),
      .gg  (gg_in[k])
    );
  end

  // Stage-1 occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
  end

  // Stage-1 payload, captured only on accept.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_p   <= p_in;
      s1_g   <= g_in;
      s1_gp  <= gp_in;
      s1_gg  <= gg_in;
      s1_cin <= (in_sub == MODE_SUB);
    end
  end

  // Group carries as one flat product sum.
  always_comb begin
    gc  = '0;
    t   = 1'b0;
    acc = 1'b0;
    gc[0] = s1_cin;
    for (int k = 1; k < NG; k++) begin
      t = s1_cin;
      for (int j = 0; j < NG; j++)
        if (j < k) t = t & s1_gp[j];
      acc = t;
      for (int j = 0; j < NG; j++) begin
        if (j < k) begin
          t = s1_gg[j];
          for (int m = 0; m < NG; m++)
            if (m > j && m < k) t = t & s1_gp[m];
          acc = acc | t;
        end
      end
      gc[k] = acc;
    end
  end

  assign cv[0] = s1_cin;

  for (genvar k = 0; k < NG; k++) begin : g_s2
    cla_group_gen #(.GROUP(GROUP)) u_grp (
      .p   (s1_p[k*GROUP +: GROUP]),
      .g   (s1_g[k*GROUP +: GROUP]),
      .cin (gc[k]),
      .c   (cv[k*GROUP+1 +: GROUP]),
      .gp  (s2_gp_unused[k]),
      .gg  (s2_gg_unused[k])
    );
  end

  if (PW > WIDTH) begin : g_pad
    logic [PW-WIDTH-1:0] pad_c_unused;
    assign pad_c_unused = cv[PW:WIDTH+1];
  end

  assign sum_nxt = s1_p[WIDTH-1:0] ^ cv[WIDTH-1:0];

  // Output stage: load, drain or hold under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      out_sum  <= sum_nxt;
      out_cout <= cv[WIDTH];
      out_ovf  <= cv[WIDTH] ^ cv[WIDTH-1];
      out_zero <= (sum_nxt == '0);
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed and random checks for the pipelined
// carry-lookahead adder/subtractor.
module tb_cla_addsub_pipe;
  import cla_addsub_pipe_pkg::*;

  localparam int W = 15;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;
  logic         rand_go;

  int n_chk;
  int n_fail;

  cla_addsub_pipe #(.WIDTH(W), .GROUP(3)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic run_op(
    input string        tag,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         sub,
    input logic [W-1:0] es,
    input logic         ec,
    input logic         eo,
    input logic         ez
  );
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, " rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({tag, " lat"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check({tag, " vld"}, 64'(out_valid), 64'd1);
    check({tag, " sum"}, 64'(out_sum), 64'(es));
    check({tag, " cout"}, 64'(out_cout), 64'(ec));
    check({tag, " ovf"}, 64'(out_ovf), 64'(eo));
    check({tag, " zero"}, 64'(out_zero), 64'(ez));
  endtask

  function automatic int cfg_w(input int i);
    case (i)
      0: return 13;
      1: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_g(input int i);
    case (i)
      0: return 3;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int CW = cfg_w(gi);
    localparam int CG = cfg_g(gi);
    logic          iv, ir, ov, orr, sub;
    logic          co, of, z, done;
    logic [CW-1:0] a, b, s;
    logic [63:0]   q[$];

    cla_addsub_pipe #(.WIDTH(CW), .GROUP(CG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (a),
      .in_b      (b),
      .in_sub    (sub),
      .out_valid (ov),
      .out_ready (orr),
      .out_sum   (s),
      .out_cout  (co),
      .out_ovf   (of),
      .out_zero  (z)
    );

    initial begin : run
      int          sent;
      int          cyc;
      ref_t        r;
      logic [63:0] e;
      iv = 1'b0; orr = 1'b1; sub = 1'b0;
      a = '0; b = '0; done = 1'b0;
      wait (rand_go);
      sent = 0;
      cyc  = 0;
      while ((sent < 2000 || q.size() > 0) &&
             cyc < 40000) begin
        @(negedge clk);
        cyc++;
        iv  = (sent < 2000) &&
              ($urandom_range(0, 3) != 0);
        a   = CW'($urandom);
        b   = CW'($urandom);
        sub = 1'($urandom_range(0, 1));
        if (sent == 0) begin
          a = '1; b = CW'(1); sub = 1'b0;
        end
        orr = (sent >= 2000) ||
              ($urandom_range(0, 3) != 0);
        #1;
        if (ov && orr) begin
          if (q.size() == 0) begin
            check($sformatf("w%0d spurious", CW),
                  64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("w%0d res", CW),
                  64'({z, of, co, s}), e);
          end
        end
        if (iv && ir) begin
          r = ref_calc(CW, 64'(a), 64'(b), sub);
          if (sent == 0)
            e = 64'({1'b1, 1'b0, 1'b1, {CW{1'b0}}});
          else
            e = 64'({r.zero, r.ovf, r.cout,
                     r.sum[CW-1:0]});
          q.push_back(e);
          sent++;
        end
      end
      iv = 1'b0;
      check($sformatf("w%0d left", CW),
            64'(q.size() + (2000 - sent)), 64'd0);
      done = 1'b1;
    end
  end

  initial begin : main
    int           nb;
    int           nr;
    int           seen;
    logic         low_seen;
    logic [W-1:0] res [5];
    int           rt [5];
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    rand_go = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst vld", 64'(out_valid), 64'd0);
    check("rst sum", 64'(out_sum), 64'd0);
    check("rst flags",
          64'({out_cout, out_ovf, out_zero}), 64'd0);
    check("rst rdy", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    run_op("add3fff", 15'h3fff, 15'h0001, 1'b0,
           15'h4000, 1'b0, 1'b1, 1'b0);
    run_op("add7fff", 15'h7fff, 15'h0001, 1'b0,
           15'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub0m1", 15'h0000, 15'h0001, 1'b1,
           15'h7fff, 1'b0, 1'b0, 1'b0);
    run_op("sub4000", 15'h4000, 15'h0001, 1'b1,
           15'h3fff, 1'b1, 1'b1, 1'b0);
    run_op("sub0m0", 15'h0000, 15'h0000, 1'b1,
           15'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub5m3", 15'h0005, 15'h0003, 1'b1,
           15'h0002, 1'b1, 1'b0, 1'b0);

    nb = 0; nr = 0; low_seen = 1'b0;
    for (int t = 0; t < 30 && nr < 5; t++) begin
      @(negedge clk);
      in_valid  = (nb < 5);
      in_a      = W'(nb + 1);
      in_b      = W'(nb + 1);
      in_sub    = 1'b0;
      out_ready = !(t >= 2 && t <= 5);
      #1;
      if (!in_ready) low_seen = 1'b1;
      if (out_valid && !out_ready)
        check("bp hold", 64'(out_sum), 64'h2);
      if (out_valid && out_ready) begin
        res[nr] = out_sum;
        rt[nr]  = t;
        nr++;
      end
      if (in_valid && in_ready) nb++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp count", 64'(nr), 64'd5);
    check("bp rdy low", 64'(low_seen), 64'd1);
    for (int i = 0; i < nr; i++) begin
      check($sformatf("bp res%0d", i),
            64'(res[i]), 64'(2 * (i + 1)));
      if (i > 0)
        check($sformatf("bp gap%0d", i),
              64'(rt[i] - rt[i-1]), 64'd1);
    end

    @(negedge clk);
    in_valid = 1'b1; in_a = 15'd7; in_b = 15'd7;
    @(negedge clk);
    in_a = 15'd9; in_b = 15'd9;
    @(negedge clk);
    in_a = 15'd11; in_b = 15'd11;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("mrst vld", 64'(out_valid), 64'd0);
    check("mrst rdy", 64'(in_ready), 64'd1);
    check("mrst sum", 64'(out_sum), 64'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mrst flush", 64'(seen), 64'd0);

    rand_go = 1'b1;
    wait (g_cfg[0].done && g_cfg[1].done &&
          g_cfg[2].done);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
